// File: rtl/shift_reg_seq_pkg.sv
// Shared types for the sequential universal shift register: shift modes and FSM states.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ASR = 2'b10,
    ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_reg_seq_if.sv
// Control/data bundle between a sequencer (master) and the shift register (slave).
interface shift_reg_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic [WIDTH-1:0] d_in;
  logic             ld;
  logic             start;
  logic [CNT_W-1:0] s_cnt;
  logic [1:0]       mode;
  logic             sl;
  logic             sr;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output d_in, ld, start, s_cnt, mode, sl, sr, abort,
    input  q, busy, done
  );

  modport slave (
    input  d_in, ld, start, s_cnt, mode, sl, sr, abort,
    output q, busy, done
  );
endinterface

// File: rtl/shift_reg_seq_step.sv
// Combinational single-bit shifter: one step of the selected mode with serial fill bits.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             sl,
  input  logic             sr,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (mode)
      SHL: q_next = {q[WIDTH-2:0], sl};
      SHR: q_next = {sr, q[WIDTH-1:1]};
      ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Sequential universal shift register: parallel load, then N single-bit shifts in a latched
// mode under a start/busy/done handshake with abort.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  shift_reg_seq_if.slave  bus
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_q),
    .mode   (mode_q),
    .sl     (bus.sl),
    .sr     (bus.sr),
    .q_next (q_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= SHL;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        // Load has priority; a coincident start is dropped, not deferred.
        if (bus.ld) begin
          q_d = bus.d_in;
        end else if (bus.start) begin
          mode_d  = mode_e'(bus.mode);
          cnt_d   = bus.s_cnt;
          state_d = (bus.s_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Abort leaves q at the last completed shift and skips the done pulse.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          q_d   = q_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.q    = q_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq (WIDTH=8): expected q per operation is queued at start
// and popped when done is seen; busy length, done width, abort, ld priority and reset checked.
module tb_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_reg_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    bus.ld   = 1'b1;
    bus.d_in = v;
    step();
    bus.ld   = 1'b0;
  endtask

  // Start an operation, wait for done (bounded), compare q against the queued expectation,
  // the busy length (N+1) and that done lasts exactly one cycle.
  task automatic run_op(input string tag, input logic [1:0] m, input int n,
                        input logic f_sl, input logic f_sr, input logic [WIDTH-1:0] e);
    int cyc;
    int busy_cyc;
    logic [WIDTH-1:0] e_pop;
    exp_q.push_back(e);
    bus.mode  = m;
    bus.s_cnt = CNT_W'(n);
    bus.sl    = f_sl;
    bus.sr    = f_sr;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 64) begin
      busy_cyc += int'(bus.busy);
      step();
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 64), 32'd1);
    busy_cyc += int'(bus.busy);
    e_pop = exp_q.pop_front();
    check({tag, "_q"}, 32'(bus.q), 32'(e_pop));
    check({tag, "_busy_len"}, 32'(busy_cyc), 32'(n + 1));
    step();
    check({tag, "_done_1cyc"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.d_in = '0; bus.ld = 1'b0; bus.start = 1'b0; bus.s_cnt = '0;
    bus.mode = 2'b00; bus.sl = 1'b0; bus.sr = 1'b0; bus.abort = 1'b0;
    step();
    step();
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;

    load(8'hA5);
    check("ld_q", 32'(bus.q), 32'hA5);
    check("ld_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);

    load(8'h81); run_op("shl3", 2'b00, 3, 1'b1, 1'b0, 8'h0F);
    load(8'h90); run_op("asr2", 2'b10, 2, 1'b0, 1'b0, 8'hE4);
    load(8'h90); run_op("shr2", 2'b01, 2, 1'b0, 1'b0, 8'h24);
    load(8'h81); run_op("rol9", 2'b11, 9, 1'b0, 1'b0, 8'h03);
    load(8'h90); run_op("asr10", 2'b10, 10, 1'b0, 1'b0, 8'hFF);
    load(8'h00); run_op("shr8", 2'b01, 8, 1'b0, 1'b1, 8'hFF);
    load(8'h5A); run_op("cnt0", 2'b00, 0, 1'b1, 1'b1, 8'h5A);

    // ld and start together: load wins, start dropped
    bus.d_in = 8'h3C; bus.ld = 1'b1;
    bus.mode = 2'b00; bus.s_cnt = CNT_W'(2); bus.start = 1'b1;
    step();
    bus.ld = 1'b0; bus.start = 1'b0;
    check("ldstart_q", 32'(bus.q), 32'h3C);
    check("ldstart_busy", 32'(bus.busy), 32'd0);
    step();
    check("ldstart_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // abort in IDLE has no effect
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_idle_q", 32'(bus.q), 32'h3C);

    // abort after two shifts, with a load attempted while busy
    load(8'h01);
    bus.mode = 2'b00; bus.s_cnt = CNT_W'(5); bus.sl = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.ld = 1'b1; bus.d_in = 8'hFF;
    step();
    bus.ld = 1'b0;
    check("abort_s1", 32'(bus.q), 32'h02);
    step();
    check("abort_s2", 32'(bus.q), 32'h04);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_q", 32'(bus.q), 32'h04);
    check("abort_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    step();
    check("abort_nodone", {30'd0, bus.busy, bus.done}, 32'd0);
    check("abort_hold", 32'(bus.q), 32'h04);

    // reset mid-shift, then a normal operation
    load(8'hA5);
    bus.mode = 2'b01; bus.s_cnt = CNT_W'(6); bus.sr = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_q", 32'(bus.q), 32'h0);
    check("midrst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    run_op("post_rst", 2'b00, 1, 1'b1, 1'b0, 8'h01);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised sequential universal shift register: loads a WIDTH-bit word and shifts it one bit per clock for a requested count in one of four modes, with start/busy/done handshake and abort. Next generation of the team's 4-bit combine+register shift register, for datapaths needing wider words, arithmetic/rotate modes and multi-cycle shifts controlled by a sequencer.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>= 2)
- CNT_W, $clog2(WIDTH)+1, width of shift-count input

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- d_in  in  WIDTH  parallel load data
- ld  in  1  parallel load request
- start  in  1  begin a shift operation
- s_cnt  in  CNT_W  number of single-bit shifts, sampled with start
- mode  in  2  shift mode, sampled with start: 00 SHL, 01 SHR, 10 ASR, 11 ROL
- sl  in  1  fill bit for SHL (enters bit 0), sampled every shift cycle
- sr  in  1  fill bit for SHR (enters bit WIDTH-1), sampled every shift cycle
- abort  in  1  terminate current operation
- q  out  WIDTH  register contents
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE.
- Reset: q = 0, state IDLE, busy = 0, done = 0, internal count = 0.
- IDLE: ld=1 -> q <= d_in, stay IDLE. Else start=1 -> latch mode, cnt <= s_cnt; s_cnt==0 -> DONE, else -> SHIFT. ld and start together: ld wins, start dropped.
- SHIFT, every cycle: q <= one-step shift of q per latched mode; cnt <= cnt-1; cnt==1 -> DONE.
  - SHL: {q[W-2:0], sl}
  - SHR: {sr, q[W-1:1]}
  - ASR: {q[W-1], q[W-1:1]}
  - ROL: {q[W-2:0], q[W-1]}
- DONE: done=1, q holds, -> IDLE next cycle.
- Counts >= WIDTH run the full count (SHL/SHR fill entirely with serial bits, ASR saturates to sign, ROL wraps modulo WIDTH). No clamping.
- ld, start, s_cnt, mode ignored while busy.
- abort=1 in SHIFT: -> IDLE next edge, q keeps value from the last completed shift (no shift on the abort edge), no done pulse. abort in IDLE/DONE: no effect.
- rst overrides everything, including mid-shift.

## Timing
- start sampled at edge k with s_cnt=N>0: q updates at edges k+1..k+N; done=1 and busy=1 in the cycle after edge k+N; busy=0 after edge k+N+1.
- N=0: done in the cycle after edge k; q unchanged.
- Total latency start -> done = N+1 cycles; next start accepted in the cycle done is high? No: accepted only in IDLE, i.e. earliest at edge k+N+2.
- ld: q = d_in visible after the sampling edge (1-cycle latency).
- done and busy are decoded from registered state (no combinational path from inputs).

## Structure
- Package shift_reg_pkg: mode enum (SHL, SHR, ASR, ROL), state enum (IDLE, SHIFT, DONE).
- Sub-module shift_step: combinational single-bit shifter (q, mode, sl, sr -> next q), parametrised by WIDTH; the top holds FSM, counter and q register.

## Test plan
- WIDTH=8: rst, then ld d_in=8'hA5 -> q=8'hA5 next cycle, busy=0, done=0.
- q=8'h81, start SHL N=3 sl=1 -> q=8'h0F after edge k+3, done one cycle, busy high 4 cycles.
- q=8'h90, ASR N=2 -> q=8'hE4; same with SHR sr=0 -> q=8'h24; ROL N=9 from 8'h81 -> q=8'h03.
- start with s_cnt=0 -> done in next cycle, q unchanged; ld+start same cycle -> load only, busy stays 0.
- SHL N=5 from 8'h01, abort after two shifts -> q=8'h04 (sl=0), IDLE, no done; ld during busy ignored.
- rst asserted mid-SHIFT -> q=0, busy=0, done=0 on next cycle; subsequent start runs normally.
